// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// and the MIPS SPECIAL funct values that the ALU control decoder maps onto them.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } mdu_state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with its own HI/LO registers.
// One bit per cycle over a shared 2*WIDTH accumulator; signs are fixed up in FIX.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fixed;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        sign_a     = ~op[0] & opA[WIDTH-1];
        sign_b     = ~op[0] & opB[WIDTH-1];
        mag_a      = sign_a ? -opA : opA;
        mag_b      = sign_b ? -opB : opB;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_part   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff   = div_part - {1'b0, opnd_q};
        prod_fixed = neg_res_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(WIDTH);
                    is_div_d  = op[1];
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    if (op[1] && (opB == '0)) begin
                        // Raw dividend parked in the accumulator; it becomes HI.
                        state_d = ZERO;
                        acc_d   = {{WIDTH{1'b0}}, opA};
                    end else if (op[1]) begin
                        state_d = CALC;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        opnd_d  = mag_b;
                    end else begin
                        state_d = CALC;
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        opnd_d  = mag_a;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // Restoring step: keep the trial subtraction only if it did not borrow.
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    dbz_d = 1'b0;
                end else begin
                    lo_d  = prod_fixed[WIDTH-1:0];
                    hi_d  = prod_fixed[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ZERO: begin
                hi_d    = acc_q[WIDTH-1:0];
                lo_d    = '1;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32; inputs driven and
// outputs sampled on the falling edge.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vec_cnt = 0;
    int err_cnt = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues an op at the current falling edge; returns edges from acceptance to done (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name, output int lat);
        lat   = -1;
        start = 1'b1; op = o; opA = a; opB = b;
        @(negedge clk);
        start = 1'b0; opA = '0; opB = '0;
        vec_cnt++;
        if (busy !== 1'b1) begin err_cnt++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        vec_cnt++; if (busy !== 1'b0)        begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_cnt++; if (done !== 1'b0)        begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
        vec_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        vec_cnt++; if (hi !== 32'h0)         begin err_cnt++; $display("FAIL reset_hi: got %h want 0", hi); end
        vec_cnt++; if (lo !== 32'h0)         begin err_cnt++; $display("FAIL reset_lo: got %h want 0", lo); end
    endtask

    task automatic test_mult();
        int lat;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5", lat);
        vec_cnt++; if (lat != 33)            begin err_cnt++; $display("FAIL mult_latency: got %0d want 33", lat); end
        vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        vec_cnt++; if (lo !== 32'hFFFF_FFF1) begin err_cnt++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
        @(negedge clk);
        vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL mult_done_one_shot: got done=%b busy=%b want 0 0", done, busy);
        end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", lat);
        vec_cnt++; if (lat != 33)            begin err_cnt++; $display("FAIL multu_latency: got %0d want 33", lat); end
        vec_cnt++; if (hi !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        vec_cnt++; if (lo !== 32'h0000_0001) begin err_cnt++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7by2", lat);
        vec_cnt++; if (lat != 33)            begin err_cnt++; $display("FAIL div_latency: got %0d want 33", lat); end
        vec_cnt++; if (lo !== 32'hFFFF_FFFD) begin err_cnt++; $display("FAIL div_q: got %h want fffffffd", lo); end
        vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL div_r: got %h want ffffffff", hi); end
        @(negedge clk);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7byneg2", lat);
        vec_cnt++; if (lo !== 32'hFFFF_FFFD) begin err_cnt++; $display("FAIL div_pn_q: got %h want fffffffd", lo); end
        vec_cnt++; if (hi !== 32'h0000_0001) begin err_cnt++; $display("FAIL div_pn_r: got %h want 00000001", hi); end
        @(negedge clk);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg", lat);
        vec_cnt++; if (lo !== 32'h8000_0000) begin err_cnt++; $display("FAIL div_minneg_q: got %h want 80000000", lo); end
        vec_cnt++; if (hi !== 32'h0)         begin err_cnt++; $display("FAIL div_minneg_r: got %h want 0", hi); end
        vec_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("FAIL div_minneg_dbz: got %b want 0", div_by_zero); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(2'b11, 32'd100, 32'd0, "divu_by0", lat);
        vec_cnt++; if (lat != 1)             begin err_cnt++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        vec_cnt++; if (hi !== 32'h64)        begin err_cnt++; $display("FAIL dbz_hi: got %h want 00000064", hi); end
        vec_cnt++; if (lo !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL dbz_lo: got %h want ffffffff", lo); end
        vec_cnt++; if (div_by_zero !== 1'b1) begin err_cnt++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
        @(negedge clk);
        run_op(2'b01, 32'd3, 32'd4, "multu_keeps_flag", lat);
        vec_cnt++; if (lo !== 32'd12)        begin err_cnt++; $display("FAIL dbz_multu_lo: got %h want 0000000c", lo); end
        vec_cnt++; if (div_by_zero !== 1'b1) begin err_cnt++; $display("FAIL dbz_sticky_mult: got %b want 1", div_by_zero); end
        @(negedge clk);
        run_op(2'b11, 32'd9, 32'd3, "divu_clears_flag", lat);
        vec_cnt++; if (lo !== 32'd3)         begin err_cnt++; $display("FAIL dbz_clear_q: got %h want 3", lo); end
        vec_cnt++; if (hi !== 32'd0)         begin err_cnt++; $display("FAIL dbz_clear_r: got %h want 0", hi); end
        vec_cnt++; if (div_by_zero !== 1'b0) begin err_cnt++; $display("FAIL dbz_cleared: got %b want 0", div_by_zero); end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int lat;
        lat   = -1;
        start = 1'b1; op = 2'b01; opA = 32'd7; opB = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; opA = 32'd2; opB = 32'd2;
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        for (int i = 6; i <= 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = i; break; end
        end
        vec_cnt++; if (lat != 33)     begin err_cnt++; $display("FAIL ignore_latency: got %0d want 33", lat); end
        vec_cnt++; if (lo !== 32'd42) begin err_cnt++; $display("FAIL ignore_lo: got %h want 0000002a", lo); end
        vec_cnt++; if (hi !== 32'd0)  begin err_cnt++; $display("FAIL ignore_mthi_dropped: got %h want 0", hi); end
        @(negedge clk);
        // MTLO alongside start must lose to start.
        start = 1'b1; op = 2'b01; opA = 32'd2; opB = 32'd3; lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        vec_cnt++; if (lo !== 32'd42) begin err_cnt++; $display("FAIL start_wins_lo: got %h want 0000002a", lo); end
        for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
        vec_cnt++; if (lo !== 32'd6)  begin err_cnt++; $display("FAIL start_wins_result: got %h want 6", lo); end
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        vec_cnt++; if (hi !== 32'h1234) begin err_cnt++; $display("FAIL mthi_idle: got %h want 00001234", hi); end
        vec_cnt++; if (lo !== 32'd6)    begin err_cnt++; $display("FAIL mthi_lo_kept: got %h want 6", lo); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "b2b_first", lat);
        vec_cnt++; if (lo !== 32'hFFFF_FFF1) begin err_cnt++; $display("FAIL b2b_first_lo: got %h want fffffff1", lo); end
        run_op(2'b11, 32'd17, 32'd5, "b2b_second", lat);
        vec_cnt++; if (lat != 33)     begin err_cnt++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        vec_cnt++; if (lo !== 32'd3)  begin err_cnt++; $display("FAIL b2b_q: got %h want 3", lo); end
        vec_cnt++; if (hi !== 32'd2)  begin err_cnt++; $display("FAIL b2b_r: got %h want 2", hi); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen_done;
        start = 1'b1; op = 2'b10; opA = 32'd1000; opB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        vec_cnt++; if (hi !== 32'h0 || lo !== 32'h0) begin
            err_cnt++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h want 0 0", hi, lo);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        vec_cnt++; if (seen_done != 0) begin err_cnt++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", seen_done); end
        run_op(2'b11, 32'd17, 32'd5, "divu_after_rst", lat);
        vec_cnt++; if (lo !== 32'd3) begin err_cnt++; $display("FAIL rst_divu_q: got %h want 3", lo); end
        vec_cnt++; if (hi !== 32'd2) begin err_cnt++; $display("FAIL rst_divu_r: got %h want 2", hi); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
